// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolution queue.
// Entry layout, statistic width and a pointer-wrap helper.
package brq_pkg;

    localparam int BRQ_DEF_ADDR_W = 16;
    localparam int BRQ_STAT_W     = 16;

    typedef struct packed {
        logic [BRQ_DEF_ADDR_W-1:0] addr;
        logic                      pred;
    } brq_entry_t;

    // Advance a circular pointer, wrapping at an arbitrary depth.
    function automatic int brq_wrap(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted branches; resolves the oldest entry,
// pops on a correct prediction and flushes with a redirect on a miss.
module branch_resolution_queue
    import brq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       push,
    input  logic [ADDR_WIDTH-1:0]      push_addr,
    input  logic                       push_pred,
    input  logic                       resolve,
    input  logic                       resolve_taken,
    output logic                       head_valid,
    output logic                       head_pred,
    output logic [ADDR_WIDTH-1:0]      head_addr,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       mispredict,
    output logic [ADDR_WIDTH-1:0]      redirect_addr,
    output logic                       overflow,
    output logic [BRQ_STAT_W-1:0]      mispredict_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  pred;
    } entry_t;

    entry_t                r_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic                  r_mispredict;
    logic [ADDR_WIDTH-1:0] r_redirect;
    logic [BRQ_STAT_W-1:0] r_mis_cnt;

    entry_t           w_head_e;
    logic             w_full;
    logic             w_empty;
    logic             w_res_valid;
    logic             w_correct;
    logic             w_mis;
    logic             w_push_ok;
    logic             w_push_drop;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;

    assign w_head_e    = r_mem[r_head];
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_res_valid = resolve && !w_empty;
    assign w_correct   = w_res_valid && (resolve_taken == w_head_e.pred);
    assign w_mis       = w_res_valid && (resolve_taken != w_head_e.pred);
    // A push alongside a miss is wrong-path work and is discarded.
    assign w_push_ok   = push && !w_mis && (!w_full || w_correct);
    assign w_push_drop = push && !w_mis && w_full && !w_correct;
    assign w_head_nxt  = PTR_W'(brq_wrap(int'(r_head), DEPTH));
    assign w_tail_nxt  = PTR_W'(brq_wrap(int'(r_tail), DEPTH));

    assign head_valid     = !w_empty;
    assign head_pred      = w_empty ? 1'b0 : w_head_e.pred;
    assign head_addr      = w_empty ? '0 : w_head_e.addr;
    assign full           = w_full;
    assign empty          = w_empty;
    assign count          = r_count;
    assign mispredict     = r_mispredict;
    assign redirect_addr  = r_redirect;
    assign overflow       = r_overflow;
    assign mispredict_cnt = r_mis_cnt;

    // Queue storage, pointers, occupancy and recovery state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_mispredict <= 1'b0;
            r_redirect   <= '0;
            r_mis_cnt    <= '0;
        end else if (stall) begin
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_mis;
            if (w_mis) begin
                r_redirect <= w_head_e.addr;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                if (r_mis_cnt != '1) begin
                    r_mis_cnt <= r_mis_cnt + 1'b1;
                end
            end else begin
                if (w_correct) begin
                    r_head <= w_head_nxt;
                end
                if (w_push_ok) begin
                    r_mem[r_tail] <= '{addr: push_addr, pred: push_pred};
                    r_tail        <= w_tail_nxt;
                end
                if (w_push_ok && !w_correct) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push_ok && w_correct) begin
                    r_count <= r_count - 1'b1;
                end
                if (w_push_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench for branch_resolution_queue (DEPTH=3).
// A queue model acts as scoreboard for head order and status outputs.
module tb_branch_resolution_queue;

    localparam int DEPTH = 3;
    localparam int AW    = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          pred;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          push;
    logic [AW-1:0] push_addr;
    logic          push_pred;
    logic          resolve;
    logic          resolve_taken;
    logic          head_valid;
    logic          head_pred;
    logic [AW-1:0] head_addr;
    logic          full;
    logic          empty;
    logic [1:0]    count;
    logic          mispredict;
    logic [AW-1:0] redirect_addr;
    logic          overflow;
    logic [15:0]   mispredict_cnt;

    int checks = 0;
    int errors = 0;

    ent_t          sb_q[$];
    logic          m_ovf;
    logic          m_mis;
    logic [AW-1:0] m_redir;
    logic [15:0]   m_cnt;

    branch_resolution_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .push(push), .push_addr(push_addr), .push_pred(push_pred),
        .resolve(resolve), .resolve_taken(resolve_taken),
        .head_valid(head_valid), .head_pred(head_pred),
        .head_addr(head_addr), .full(full), .empty(empty),
        .count(count), .mispredict(mispredict),
        .redirect_addr(redirect_addr), .overflow(overflow),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        logic [AW-1:0] ea;
        logic          ep;
        ea = (sb_q.size() > 0) ? sb_q[0].addr : '0;
        ep = (sb_q.size() > 0) ? sb_q[0].pred : 1'b0;
        chk({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(sb_q.size() == DEPTH));
        chk({tag, ".hvalid"}, 32'(head_valid), 32'(sb_q.size() != 0));
        chk({tag, ".haddr"}, 32'(head_addr), 32'(ea));
        chk({tag, ".hpred"}, 32'(head_pred), 32'(ep));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".mis"}, 32'(mispredict), 32'(m_mis));
        chk({tag, ".redir"}, 32'(redirect_addr), 32'(m_redir));
        chk({tag, ".mcnt"}, 32'(mispredict_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ovf   = 1'b0;
        m_mis   = 1'b0;
        m_redir = '0;
        m_cnt   = '0;
    endtask

    // One clock of stimulus; model updated, DUT checked #1 after the edge.
    task automatic step(input string tag, input logic st, input logic p,
                        input logic [AW-1:0] a, input logic pp,
                        input logic r, input logic rt);
        logic rv, cor, mis, was_full;
        stall         = st;
        push          = p;
        push_addr     = a;
        push_pred     = pp;
        resolve       = r;
        resolve_taken = rt;
        #1;
        if (st) begin
            m_mis = 1'b0;
        end else begin
            rv  = r && (sb_q.size() > 0);
            cor = rv && (rt == sb_q[0].pred);
            mis = rv && (rt != sb_q[0].pred);
            if (rv) begin
                chk({tag, ".pre_haddr"}, 32'(head_addr), 32'(sb_q[0].addr));
            end
            was_full = (sb_q.size() == DEPTH);
            if (mis) begin
                m_redir = sb_q[0].addr;
                sb_q.delete();
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                if (cor) void'(sb_q.pop_front());
                if (p) begin
                    if (!was_full || cor) sb_q.push_back('{addr: a, pred: pp});
                    else m_ovf = 1'b1;
                end
            end
            m_mis = mis;
        end
        @(posedge clk);
        #1;
        chk_all(tag);
        stall   = 1'b0;
        push    = 1'b0;
        resolve = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        push = 1'b0;
        push_addr = '0;
        push_pred = 1'b0;
        resolve = 1'b0;
        resolve_taken = 1'b0;
        model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;

        step("pushA", 0, 1, 16'h1000, 1, 0, 0);
        step("pushB", 0, 1, 16'h2000, 0, 0, 0);
        step("resA", 0, 0, 16'h0, 0, 1, 1);
        step("resB", 0, 0, 16'h0, 0, 1, 0);
        step("resEmpty", 0, 0, 16'h0, 0, 1, 1);

        step("fill1", 0, 1, 16'h1111, 1, 0, 0);
        step("fill2", 0, 1, 16'h1234, 0, 0, 0);
        step("fill3", 0, 1, 16'h3333, 1, 0, 0);
        step("ovfPush", 0, 1, 16'h4444, 1, 0, 0);
        step("pushRes", 0, 1, 16'h5555, 1, 1, 1);
        step("misPush", 0, 1, 16'h6666, 1, 1, 1);
        step("misDrop", 0, 0, 16'h0, 0, 0, 0);

        step("s1", 0, 1, 16'h7001, 1, 0, 0);
        step("s2", 0, 1, 16'h7002, 0, 0, 0);
        step("stallPR", 1, 1, 16'h7003, 1, 1, 1);
        step("misB", 0, 0, 16'h0, 0, 1, 0);
        step("stallMis", 1, 1, 16'h7004, 1, 1, 1);

        for (int i = 0; i < 10; i++) begin
            logic rr, tt;
            rr = (sb_q.size() >= 2);
            tt = rr ? sb_q[0].pred : 1'b0;
            step($sformatf("wrap%0d", i), 0, 1, 16'(16'hA000 + i),
                 1'($urandom_range(0, 1)), rr, tt);
        end
        while (sb_q.size() > 1) begin
            step("drain", 0, 0, 16'h0, 0, 1, sb_q[0].pred);
        end
        step("lastMis", 0, 0, 16'h0, 0, 1, ~sb_q[0].pred);

        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("asyncRst");
        @(negedge clk);
        rst_n = 1'b1;
        step("postRst", 0, 1, 16'hBEEF, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
